sonar_scheduler: RTL and testbench

- Sequences the six robot sonars one at a time, round-robin, so no two sonars fire together and cross-talk is avoided.
- For each sonar it generates the trigger pulse, measures the echo pulse width in clk cycles, applies a timeout, and publishes a per-sonar range word.
- Sits between the GPIO1 sonar pins and the distance/SPI path. The enable mask and the run bit come from the PIC32 Config register.

---
 rtl/sonar_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// Round-robin sonar sequencer: trigger, echo width measurement, timeout and range publication.
// Optional macro SONAR_AVG_EN: averages each valid sample with the previous slot value.
module sonar_scheduler #(
  parameter int unsigned N_SONAR        = 6,
  parameter int unsigned RW             = 20,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned GUARD_CYCLES   = 250000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [N_SONAR-1:0]          enable_mask,
  input  logic [N_SONAR-1:0]          echo,
  output logic [N_SONAR-1:0]          trig,
  output logic [N_SONAR*RW-1:0]       range_flat,
  output logic [N_SONAR-1:0]          timeout_flags,
  output logic                        done,
  output logic [$clog2(N_SONAR)-1:0]  cur_idx,
  output logic                        busy
);

  localparam int unsigned IW   = $clog2(N_SONAR);
  localparam int unsigned MAXA = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int unsigned MAXC = (MAXA > TRIG_CYCLES) ? MAXA : TRIG_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GUARD
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       cur_idx_q, cur_idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       wid_q, wid_d;
  logic [N_SONAR-1:0]  trig_q, trig_d;
  logic [RW-1:0]       range_q [N_SONAR];
  logic [RW-1:0]       range_d [N_SONAR];
  logic [N_SONAR-1:0]  tflag_q, tflag_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [N_SONAR-1:0]  sync1_q, sync1_d;
  logic [N_SONAR-1:0]  sync2_q, sync2_d;

  logic [IW-1:0]       sel_idx;
  logic                sel_found;
  logic [IW-1:0]       cand;
  logic                es_cur;
  logic                tmo_hit;
  logic                wr_valid;
  logic                wr_tmo;
  logic [RW-1:0]       wr_val;

`ifdef SONAR_AVG_EN
  // Set when the next valid sample for a slot must be stored without averaging.
  logic [N_SONAR-1:0]  fresh_q, fresh_d;
  logic [RW:0]         avg_sum;
`endif

  assign sync1_d = echo;
  assign sync2_d = sync1_q;

  // Next enabled sonar strictly after cur_idx, wrapping; a single enabled bit reselects itself.
  always_comb begin
    sel_idx   = cur_idx_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_SONAR; k++) begin
      cand = IW'((32'(cur_idx_q) + k) % N_SONAR);
      if (!sel_found && enable_mask[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    es_cur  = sync2_q[cur_idx_q];
    tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`ifdef SONAR_AVG_EN
    avg_sum = {1'b0, range_q[cur_idx_q]} + {1'b0, wid_q};
    wr_val  = fresh_q[cur_idx_q] ? wid_q : avg_sum[RW:1];
`else
    wr_val  = wid_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    cnt_d     = cnt_q;
    wid_d     = wid_q;
    trig_d    = '0;
    range_d   = range_q;
    tflag_d   = tflag_q;
    done_d    = 1'b0;
    wr_valid  = 1'b0;
    wr_tmo    = 1'b0;
`ifdef SONAR_AVG_EN
    fresh_d   = fresh_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (run && (|enable_mask)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (sel_found) begin
          cur_idx_d       = sel_idx;
          trig_d[sel_idx] = 1'b1;
          cnt_d           = '0;
          state_d         = S_TRIG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_RISE;
        end else begin
          cnt_d             = cnt_q + CW'(1);
          trig_d[cur_idx_q] = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        cnt_d = cnt_q + CW'(1);
        if (tmo_hit) begin
          wr_tmo = 1'b1;
        end else if (es_cur) begin
          // The rising cycle itself counts as the first high cycle.
          wid_d   = RW'(1);
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_q + CW'(1);
        if (!es_cur) begin
          wr_valid = 1'b1;
        end else if (tmo_hit) begin
          wr_tmo = 1'b1;
        end else if (wid_q != {RW{1'b1}}) begin
          wid_d = wid_q + RW'(1);
        end
      end
      S_GUARD: begin
        if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (run && (|enable_mask)) ? S_SELECT : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_valid) begin
      range_d[cur_idx_q] = wr_val;
      tflag_d[cur_idx_q] = 1'b0;
      done_d             = 1'b1;
      cnt_d              = '0;
      state_d            = S_GUARD;
`ifdef SONAR_AVG_EN
      fresh_d[cur_idx_q] = 1'b0;
`endif
    end

    if (wr_tmo) begin
      range_d[cur_idx_q] = {RW{1'b1}};
      tflag_d[cur_idx_q] = 1'b1;
      done_d             = 1'b1;
      cnt_d              = '0;
      state_d            = S_GUARD;
`ifdef SONAR_AVG_EN
      fresh_d[cur_idx_q] = 1'b1;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cur_idx_q <= IW'(N_SONAR - 1);
      cnt_q     <= '0;
      wid_q     <= '0;
      trig_q    <= '0;
      tflag_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int i = 0; i < N_SONAR; i++) range_q[i] <= '0;
`ifdef SONAR_AVG_EN
      fresh_q   <= '1;
`endif
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      cnt_q     <= cnt_d;
      wid_q     <= wid_d;
      trig_q    <= trig_d;
      tflag_q   <= tflag_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      for (int i = 0; i < N_SONAR; i++) range_q[i] <= range_d[i];
`ifdef SONAR_AVG_EN
      fresh_q   <= fresh_d;
`endif
    end
  end

  assign trig          = trig_q;
  assign timeout_flags = tflag_q;
  assign done          = done_q;
  assign cur_idx       = cur_idx_q;
  assign busy          = busy_q;

  for (genvar g = 0; g < N_SONAR; g++) begin : g_flat
    assign range_flat[g*RW +: RW] = range_q[g];
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with short trigger/timeout/guard timing.
module tb_sonar_scheduler;

  localparam int unsigned N  = 6;
  localparam int unsigned RW = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [N-1:0]    enable_mask;
  logic [N-1:0]    echo;
  logic [N-1:0]    trig;
  logic [N*RW-1:0] range_flat;
  logic [N-1:0]    timeout_flags;
  logic            done;
  logic [2:0]      cur_idx;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit          multi_seen = 1'b0;
  logic [N-1:0] trig_seen = '0;

`ifdef SONAR_AVG_EN
  localparam logic [RW-1:0] EXP_S0_B = 20'd50;
  localparam logic [RW-1:0] EXP_S0_C = 20'd45;
`else
  localparam logic [RW-1:0] EXP_S0_B = 20'd60;
  localparam logic [RW-1:0] EXP_S0_C = 20'd40;
`endif

  sonar_scheduler #(
    .N_SONAR(N), .RW(RW), .TRIG_CYCLES(5), .TIMEOUT_CYCLES(100), .GUARD_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .enable_mask(enable_mask), .echo(echo),
    .trig(trig), .range_flat(range_flat), .timeout_flags(timeout_flags),
    .done(done), .cur_idx(cur_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(trig) > 1) multi_seen <= 1'b1;
    trig_seen <= trig_seen | trig;
  end

  function automatic logic [RW-1:0] slot(input int i);
    return range_flat[i*RW +: RW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input logic [N-1:0] m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if ((trig & m) != '0) ok = 1'b1;
    end
  endtask

  task automatic measure_trig(input int idx, output int w);
    w = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (trig[idx]) w++;
      else break;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      n++;
      if (done) break;
    end
    if (!done) n = -1;
  endtask

  task automatic pulse_echo(input int idx, input int dly, input int w);
    repeat (dly) step();
    echo[idx] = 1'b1;
    repeat (w) step();
    echo[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; enable_mask = '0; echo = '0;
    repeat (3) step();
    n_checks++; if (trig !== '0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
    n_checks++; if (range_flat !== '0) begin n_fail++; $display("FAIL reset_range: got %h want 0", range_flat); end
    n_checks++; if (timeout_flags !== '0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", timeout_flags); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (cur_idx !== 3'd5) begin n_fail++; $display("FAIL reset_cur_idx: got %0d want 5", cur_idx); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_measure();
    bit ok; int w; int n;
    enable_mask = 6'b000101; run = 1'b1;
    wait_trig('1, 20, ok);
    n_checks++; if (!ok || trig !== 6'b000001) begin n_fail++; $display("FAIL first_trig: got %b want 000001", trig); end
    measure_trig(0, w);
    n_checks++; if (w != 5) begin n_fail++; $display("FAIL trig0_width: got %0d want 5", w); end
    pulse_echo(0, 7, 40);
    wait_done(200, n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL s0_done: got no done want pulse"); end
    n_checks++; if (slot(0) !== 20'd40) begin n_fail++; $display("FAIL s0_range: got %0d want 40", slot(0)); end
    n_checks++; if (timeout_flags[0] !== 1'b0) begin n_fail++; $display("FAIL s0_flag: got %b want 0", timeout_flags[0]); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_timeout();
    bit ok; int w; int n;
    wait_trig('1, 40, ok);
    n_checks++; if (!ok || trig !== 6'b000100) begin n_fail++; $display("FAIL second_trig: got %b want 000100", trig); end
    measure_trig(2, w);
    n_checks++; if (w != 5) begin n_fail++; $display("FAIL trig2_width: got %0d want 5", w); end
    wait_done(200, n);
    n_checks++; if (n != 100) begin n_fail++; $display("FAIL timeout_latency: got %0d want 100", n); end
    n_checks++; if (slot(2) !== 20'hFFFFF) begin n_fail++; $display("FAIL s2_timeout_range: got %h want fffff", slot(2)); end
    n_checks++; if (timeout_flags[2] !== 1'b1) begin n_fail++; $display("FAIL s2_timeout_flag: got %b want 1", timeout_flags[2]); end
    wait_trig('1, 40, ok);
    n_checks++; if (!ok || trig !== 6'b000001) begin n_fail++; $display("FAIL third_trig: got %b want 000001", trig); end
    measure_trig(0, w);
    pulse_echo(0, 7, 60);
    wait_done(200, n);
    n_checks++; if (n < 0 || slot(0) !== EXP_S0_B) begin n_fail++; $display("FAIL s0_second: got %0d want %0d", slot(0), EXP_S0_B); end
    wait_trig('1, 40, ok);
    n_checks++; if (!ok || trig !== 6'b000100) begin n_fail++; $display("FAIL fourth_trig: got %b want 000100", trig); end
    measure_trig(2, w);
    pulse_echo(2, 7, 30);
    wait_done(200, n);
    n_checks++; if (n < 0 || slot(2) !== 20'd30) begin n_fail++; $display("FAIL s2_recover_range: got %0d want 30", slot(2)); end
    n_checks++; if (timeout_flags[2] !== 1'b0) begin n_fail++; $display("FAIL s2_recover_flag: got %b want 0", timeout_flags[2]); end
  endtask

  task automatic test_mask_change();
    bit ok; int w; int n;
    wait_trig('1, 40, ok);
    n_checks++; if (!ok || trig !== 6'b000001) begin n_fail++; $display("FAIL fifth_trig: got %b want 000001", trig); end
    measure_trig(0, w);
    repeat (7) step();
    echo[0] = 1'b1;
    repeat (10) step();
    enable_mask = 6'b100000;
    repeat (30) step();
    echo[0] = 1'b0;
    wait_done(200, n);
    n_checks++; if (n < 0 || slot(0) !== EXP_S0_C) begin n_fail++; $display("FAIL s0_mask_change: got %0d want %0d", slot(0), EXP_S0_C); end
    wait_trig('1, 40, ok);
    n_checks++; if (!ok || trig !== 6'b100000) begin n_fail++; $display("FAIL new_mask_trig: got %b want 100000", trig); end
    n_checks++; if (slot(2) !== 20'd30) begin n_fail++; $display("FAIL s2_retained: got %0d want 30", slot(2)); end
    n_checks++; if (multi_seen !== 1'b0) begin n_fail++; $display("FAIL trig_onehot: got multi=%b want 0", multi_seen); end
    n_checks++; if (trig_seen[1] !== 1'b0) begin n_fail++; $display("FAIL trig1_quiet: got %b want 0", trig_seen[1]); end
  endtask

  task automatic test_run_stop();
    int w; int n; int seen;
    measure_trig(5, w);
    n_checks++; if (w != 5) begin n_fail++; $display("FAIL trig5_width: got %0d want 5", w); end
    repeat (2) step();
    run = 1'b0;
    pulse_echo(5, 5, 12);
    wait_done(200, n);
    n_checks++; if (n < 0 || slot(5) !== 20'd12) begin n_fail++; $display("FAIL s5_range: got %0d want 12", slot(5)); end
    n_checks++; if (timeout_flags !== 6'b000000) begin n_fail++; $display("FAIL flags_after_stop: got %b want 000000", timeout_flags); end
    repeat (5) step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_guard: got %b want 1", busy); end
    repeat (7) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (trig != '0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL no_trig_idle: got %0d want 0", seen); end
    n_checks++; if (slot(1) !== '0 || slot(3) !== '0 || slot(4) !== '0) begin
      n_fail++; $display("FAIL disabled_slots: got %0d/%0d/%0d want 0/0/0", slot(1), slot(3), slot(4));
    end
    n_checks++; if (slot(0) !== EXP_S0_C) begin n_fail++; $display("FAIL s0_retained: got %0d want %0d", slot(0), EXP_S0_C); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    enable_mask = 6'b100100; run = 1'b1;
    wait_trig('1, 20, ok);
    n_checks++; if (!ok || trig !== 6'b000100) begin n_fail++; $display("FAIL pre_reset_trig: got %b want 000100", trig); end
    step();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (trig !== '0) begin n_fail++; $display("FAIL reset_trig_drop: got %b want 0", trig); end
    n_checks++; if (range_flat !== '0) begin n_fail++; $display("FAIL reset_mid_range: got %h want 0", range_flat); end
    n_checks++; if (timeout_flags !== '0) begin n_fail++; $display("FAIL reset_mid_flags: got %b want 0", timeout_flags); end
    n_checks++; if (cur_idx !== 3'd5) begin n_fail++; $display("FAIL reset_mid_idx: got %0d want 5", cur_idx); end
    repeat (2) step();
    reset = 1'b1;
    wait_trig('1, 20, ok);
    n_checks++; if (!ok || trig !== 6'b000100) begin n_fail++; $display("FAIL post_reset_trig: got %b want 000100", trig); end
  endtask

  initial begin
    test_reset();
    test_measure();
    test_timeout();
    test_mask_change();
    test_run_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
